lsu: RTL and testbench

Load/store unit for the KCP53K cpu2 core. It accepts one memory request at a time from the execute stage, checks alignment, and runs a single pipelined Wishbone B4 transaction. It steers and extends load data and returns one response per request with a fault cause. A bus-watchdog timeout aborts hung cycles.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 46 ++++
 rtl/lsu.sv | 176 +++++++++++++++++
 tb/tb_lsu.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared codes for the load/store unit: access sizes, fault causes,
// FSM state encoding and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_MIS  = 2'b01;
  localparam logic [1:0] C_BUS  = 2'b10;
  localparam logic [1:0] C_TMO  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;
  localparam logic [1:0] ST_RESP = 2'b11;

  // size 11 is illegal and reported as misaligned
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    return (size == 2'b11)
        || (size == SZ_H && a[0])
        || (size == SZ_W && a != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store sel/data replication and load
// extract + sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_a_i,
  input  logic [31:0] st_dat_i,
  output logic [3:0]  st_sel_o,
  output logic [31:0] st_dat_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_a_i,
  input  logic        ld_sgn_i,
  input  logic [31:0] ld_dat_i,
  output logic [31:0] ld_res_o
);

  logic [31:0] sh;

  always_comb begin
    st_sel_o = 4'b1111;
    st_dat_o = st_dat_i;
    unique case (st_size_i)
      SZ_B: begin
        st_sel_o = 4'b0001 << st_a_i;
        st_dat_o = {4{st_dat_i[7:0]}};
      end
      SZ_H: begin
        st_sel_o = 4'b0011 << st_a_i;
        st_dat_o = {2{st_dat_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sh = ld_dat_i >> {ld_a_i, 3'b000};
    ld_res_o = sh;
    unique case (ld_size_i)
      SZ_B: ld_res_o = {{24{ld_sgn_i & sh[7]}}, sh[7:0]};
      SZ_H: ld_res_o = {{16{ld_sgn_i & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, pipelined Wishbone B4 master,
// alignment check, load extension and a bus watchdog.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 12,
  parameter int unsigned TIMEOUT   = 12'hFFF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdat_i,
  output logic        rvalid_o,
  output logic [31:0] rdat_o,
  output logic        fault_o,
  output logic [1:0]  cause_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_stall_i
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  a_q, a_d;
  logic        sgn_q, sgn_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdat_q, rdat_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  logic [3:0]  st_sel;
  logic [31:0] st_dat;
  logic [31:0] ld_res;
  logic        in_resp, busy, accept, take, tmo;

  lsu_align u_align (
    .st_size_i (size_i),
    .st_a_i    (addr_i[1:0]),
    .st_dat_i  (wdat_i),
    .st_sel_o  (st_sel),
    .st_dat_o  (st_dat),
    .ld_size_i (size_q),
    .ld_a_i    (a_q),
    .ld_sgn_i  (sgn_q),
    .ld_dat_i  (wbm_dat_i),
    .ld_res_o  (ld_res)
  );

  assign in_resp = (state_q == ST_RESP);
  assign busy    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign ready_o = (state_q == ST_IDLE) || in_resp;
  assign accept  = valid_i && ready_o;
  // a response only counts once the strobe has been taken
  assign take    = (state_q == ST_WAIT) || !wbm_stall_i;
  assign tmo     = (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    a_d     = a_q;
    sgn_d   = sgn_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    fault_d = fault_q;
    cause_d = cause_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_REQ, ST_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (take && wbm_err_i) begin
          state_d = ST_RESP;
          fault_d = 1'b1;
          cause_d = C_BUS;
          rdat_d  = '0;
        end else if (take && wbm_ack_i) begin
          state_d = ST_RESP;
          rdat_d  = we_q ? '0 : ld_res;
        end else if (tmo) begin
          state_d = ST_RESP;
          fault_d = 1'b1;
          cause_d = C_TMO;
          rdat_d  = '0;
        end else if (take) begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        if (accept) begin
          we_d    = we_i;
          size_d  = size_i;
          a_d     = addr_i[1:0];
          sgn_d   = signed_i;
          rdat_d  = '0;
          if (misaligned(size_i, addr_i[1:0])) begin
            state_d = ST_RESP;
            fault_d = 1'b1;
            cause_d = C_MIS;
          end else begin
            state_d = ST_REQ;
            fault_d = 1'b0;
            cause_d = C_NONE;
            adr_d   = addr_i[31:2];
            sel_d   = st_sel;
            dat_d   = st_dat;
            wd_d    = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      a_q     <= 2'b00;
      sgn_q   <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= C_NONE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      a_q     <= a_d;
      sgn_q   <= sgn_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      wd_q    <= wd_d;
    end
  end

  assign rvalid_o  = in_resp;
  assign fault_o   = in_resp && fault_q;
  assign cause_o   = in_resp ? cause_q : C_NONE;
  assign rdat_o    = in_resp ? rdat_q : '0;
  assign wbm_cyc_o = busy;
  assign wbm_stb_o = (state_q == ST_REQ);
  assign wbm_we_o  = busy && we_q;
  assign wbm_sel_o = busy ? sel_q : 4'b0000;
  assign wbm_adr_o = {adr_q, 2'b00};
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu with a byte-level reference model;
// slave behaviour is scripted per request (stall, latency, ack/err).
module tb_lsu;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        signed_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdat_i = '0;
  logic        rvalid_o;
  logic [31:0] rdat_o;
  logic        fault_o;
  logic [1:0]  cause_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        wbm_stall_i = 1'b0;

  int tests = 0;
  int fails = 0;

  lsu #(.TIMEOUT_W(12), .TIMEOUT(TO)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .we_i        (we_i),
    .size_i      (size_i),
    .signed_i    (signed_i),
    .addr_i      (addr_i),
    .wdat_i      (wdat_i),
    .rvalid_o    (rvalid_o),
    .rdat_o      (rdat_o),
    .fault_o     (fault_o),
    .cause_o     (cause_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i),
    .wbm_stall_i (wbm_stall_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  function automatic bit ref_mis(input int size, input logic [31:0] addr);
    if (size == 3) return 1'b1;
    return (int'(addr[1:0]) % (1 << size)) != 0;
  endfunction

  function automatic logic [3:0] ref_sel(input int size, input int a);
    int n;
    n = 1 << size;
    return 4'(((1 << n) - 1) << a);
  endfunction

  function automatic logic [31:0] ref_wdat(input int size,
                                           input logic [31:0] w);
    if (size == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  // assemble the addressed bytes little-endian, then extend numerically
  function automatic logic [31:0] ref_load(input logic [31:0] bus,
                                           input int size, input int a,
                                           input bit sgn);
    longint v;
    longint lim;
    int n;
    n = 1 << size;
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'((bus >> (8 * (a + i))) & 32'hFF) << (8 * i);
    lim = longint'(1) << (8 * n - 1);
    if (sgn && v >= lim) v -= 2 * lim;
    return v[31:0];
  endfunction

  // kind: 0 ack, 1 err, 2 ack+err. rc > TO-1 means the slave stays silent.
  // Entered at a negedge with ready_o expected high; returns at the
  // negedge where the response is expected (DUT sits in RESP).
  task automatic do_req(input bit we, input int size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int stall_n, input int lat, input int kind,
                        input logic [31:0] rd);
    int rc, last;
    bit tmo;
    logic [31:0] exp_rdat;
    logic [1:0] exp_cause;
    check("ready", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    we_i = we;
    size_i = 2'(size);
    signed_i = sgn;
    addr_i = addr;
    wdat_i = wd;
    step();
    valid_i = 1'b0;
    wdat_i = $urandom;
    if (ref_mis(size, addr)) begin
      check("mis_cyc", 32'(wbm_cyc_o), 32'd0);
      check("mis_rvalid", 32'(rvalid_o), 32'd1);
      check("mis_fault", 32'(fault_o), 32'd1);
      check("mis_cause", 32'(cause_o), 32'd1);
      check("mis_rdat", rdat_o, 32'd0);
      return;
    end
    rc = stall_n + lat;
    tmo = (rc > TO - 1);
    last = tmo ? TO - 1 : rc;
    for (int n = 0; n <= last; n++) begin
      check("cyc", 32'(wbm_cyc_o), 32'd1);
      check("stb", 32'(wbm_stb_o), 32'(n <= stall_n));
      check("adr", wbm_adr_o, addr & 32'hFFFF_FFFC);
      check("sel", 32'(wbm_sel_o), 32'(ref_sel(size, int'(addr[1:0]))));
      check("we", 32'(wbm_we_o), 32'(we));
      if (we) check("wdat", wbm_dat_o, ref_wdat(size, wd));
      wbm_stall_i = (n < stall_n);
      if (n == rc && !tmo) begin
        wbm_ack_i = (kind != 1);
        wbm_err_i = (kind != 0);
        wbm_dat_i = rd;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = $urandom;
      end
      step();
    end
    wbm_stall_i = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    if (tmo) begin
      exp_cause = 2'b11;
      exp_rdat = '0;
    end else if (kind != 0) begin
      exp_cause = 2'b10;
      exp_rdat = '0;
    end else begin
      exp_cause = 2'b00;
      exp_rdat = we ? 32'd0 : ref_load(rd, size, int'(addr[1:0]), sgn);
    end
    check("resp_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rvalid", 32'(rvalid_o), 32'd1);
    check("fault", 32'(fault_o), 32'(exp_cause != 2'b00));
    check("cause", 32'(cause_o), 32'(exp_cause));
    check("rdat", rdat_o, exp_rdat);
  endtask

  task automatic idle_check();
    step();
    check("rvalid_one", 32'(rvalid_o), 32'd0);
    check("idle_cause", 32'(cause_o), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int size, stall_n, lat, kind;
    logic [31:0] addr;
    bit we, sgn;

    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_sel", 32'(wbm_sel_o), 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_rdat", rdat_o, 32'd0);
    check("rst_cause", 32'(cause_o), 32'd0);
    reset_i = 1'b1;
    step();

    // directed cases
    do_req(1, 2, 0, 32'h100, 32'h1234_5678, 0, 0, 0, 32'h0);
    idle_check();
    do_req(0, 0, 1, 32'h103, 32'h0, 0, 0, 0, 32'h80AB_CDEF);
    do_req(0, 0, 0, 32'h103, 32'h0, 0, 1, 0, 32'h80AB_CDEF);
    do_req(0, 1, 0, 32'h101, 32'h0, 0, 0, 0, 32'h0);
    do_req(0, 3, 0, 32'h100, 32'h0, 0, 0, 0, 32'h0);
    do_req(0, 1, 1, 32'h102, 32'h0, 3, 0, 0, 32'hC001_0000);
    do_req(1, 0, 0, 32'h201, 32'hAA, 3, 2, 2, 32'h0);
    do_req(0, 2, 0, 32'h300, 32'h0, 1, 20, 0, 32'h0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hDEAD_BEEF;
    step();
    wbm_ack_i = 1'b0;
    check("late_ack_rvalid", 32'(rvalid_o), 32'd0);
    check("late_ack_cyc", 32'(wbm_cyc_o), 32'd0);
    do_req(0, 2, 0, 32'h400, 32'h0, 0, 2, 0, 32'h5555_AAAA);
    idle_check();

    // reset while waiting for the slave
    valid_i = 1'b1;
    we_i = 1'b0;
    size_i = 2'b10;
    addr_i = 32'h500;
    step();
    valid_i = 1'b0;
    step();
    check("wait_cyc", 32'(wbm_cyc_o), 32'd1);
    check("wait_stb", 32'(wbm_stb_o), 32'd0);
    #2 reset_i = 1'b0;
    #1;
    check("arst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("arst_stb", 32'(wbm_stb_o), 32'd0);
    step();
    check("arst_rvalid", 32'(rvalid_o), 32'd0);
    reset_i = 1'b1;
    step();
    do_req(1, 1, 0, 32'h602, 32'hBEEF, 0, 0, 0, 32'h0);

    // randomized traffic
    for (int t = 0; t < 120; t++) begin
      we = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      size = $urandom_range(0, 3);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0 && size != 3)
        addr = addr & ~32'((1 << size) - 1);
      stall_n = $urandom_range(0, 3);
      lat = ($urandom_range(0, 15) == 0) ? 9 : $urandom_range(0, 3);
      kind = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      do_req(we, size, sgn, addr, $urandom, stall_n, lat, kind, $urandom);
      if ($urandom_range(0, 2) == 0) idle_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
